// File: rtl/mem_a_pingpong.sv
// rtl/mem_a_pingpong.sv - double-buffered A-operand store feeding the systolic array's left edge
// Optional diagonal skew on the output lanes is enabled by defining MEMA_SKEW_EN.
module mem_a_pingpong #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DIM)-1:0]     wr_row,
  input  logic [DIM*BITS_AB-1:0]     wr_data,
  input  logic                       wr_commit,
  output logic                       wr_ready,
  input  logic                       rd_start,
  output logic                       rd_busy,
  output logic                       rd_done,
  output logic [DIM*BITS_AB-1:0]     a_out,
  output logic [1:0]                 full_cnt
);

  localparam int IDX_W = $clog2(DIM);
  localparam int T_W   = $clog2(2 * DIM);
  localparam int ROW_W = DIM * BITS_AB;
`ifdef MEMA_SKEW_EN
  localparam int STREAM_LEN = 2 * DIM - 1;
`else
  localparam int STREAM_LEN = DIM;
`endif

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t           state_q, state_d;
  logic [T_W-1:0]   t_q, t_d;
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [ROW_W-1:0] a_out_q, a_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [ROW_W-1:0] mem_q [2][DIM];
  logic [ROW_W-1:0] mem_d [2][DIM];
  logic [ROW_W-1:0] lane_flat;

  // Each lane picks its column for the current stream step; out-of-window lanes read as zero.
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic             lane_vld;
    logic [IDX_W-1:0] col_idx;
`ifdef MEMA_SKEW_EN
    logic [T_W-1:0]   col_t;
    assign col_t    = t_q - T_W'(i);
    assign lane_vld = (t_q >= T_W'(i)) && (col_t < T_W'(DIM));
    assign col_idx  = col_t[IDX_W-1:0];
`else
    assign lane_vld = t_q < T_W'(DIM);
    assign col_idx  = t_q[IDX_W-1:0];
`endif
    assign lane_flat[i*BITS_AB +: BITS_AB] =
      lane_vld ? mem_q[rd_bank_q][i][col_idx*BITS_AB +: BITS_AB] : '0;
  end

  assign wr_ready = !full_q[wr_bank_q];
  assign full_cnt = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  assign a_out    = a_out_q;
  assign rd_busy  = busy_q;
  assign rd_done  = done_q;

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    mem_d     = mem_q;
    a_out_d   = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    if (wr_en && wr_ready) begin
      mem_d[wr_bank_q][wr_row] = wr_data;
    end
    if (wr_commit && wr_ready) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end

    // The FSM stays in STREAM through the rd_done cycle, so the bank is released one
    // edge after the last output is registered and a start in that cycle is ignored.
    case (state_q)
      S_IDLE: begin
        if (rd_start && full_q[rd_bank_q]) begin
          state_d = S_STREAM;
          t_d     = '0;
        end
      end
      S_STREAM: begin
        if (t_q == T_W'(STREAM_LEN)) begin
          state_d           = S_IDLE;
          t_d               = '0;
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
        end else begin
          t_d     = t_q + T_W'(1);
          a_out_d = lane_flat;
          busy_d  = 1'b1;
          done_d  = (t_q == T_W'(STREAM_LEN - 1));
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      a_out_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      a_out_q   <= a_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_mem_a_pingpong.sv
// tb/tb_mem_a_pingpong.sv - directed bench for mem_a_pingpong (DIM=4, follows MEMA_SKEW_EN)
module tb_mem_a_pingpong;

`ifdef MEMA_SKEW_EN
  localparam int LEN = 7;
  localparam logic [31:0] HAND_FIRST = 32'h0000_0001;
  localparam logic [31:0] HAND_LAST  = 32'h1000_0000;
`else
  localparam int LEN = 4;
  localparam logic [31:0] HAND_FIRST = 32'h0D09_0501;
  localparam logic [31:0] HAND_LAST  = 32'h100C_0804;
`endif

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_row;
  logic [31:0] wr_data;
  logic        wr_commit;
  logic        wr_ready;
  logic        rd_start;
  logic        rd_busy;
  logic        rd_done;
  logic [31:0] a_out;
  logic [1:0]  full_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] first_v, last_v, dummy_f, dummy_l;
  logic        rdy_done, dummy_r;

  mem_a_pingpong #(.BITS_AB(8), .DIM(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .wr_commit (wr_commit),
    .wr_ready  (wr_ready),
    .rd_start  (rd_start),
    .rd_busy   (rd_busy),
    .rd_done   (rd_done),
    .a_out     (a_out),
    .full_cnt  (full_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] row_of(input int base, input int r);
    logic [31:0] d = '0;
    for (int j = 0; j < 4; j++) d[j*8 +: 8] = 8'(base + 4*r + j + 1);
    return d;
  endfunction

  // Tile element A[i][c] = base + 4i + c + 1; lane i carries column t-i (skewed) or t.
  function automatic logic [31:0] exp_aout(input int base, input int t);
    logic [31:0] r = '0;
    int c;
    for (int i = 0; i < 4; i++) begin
`ifdef MEMA_SKEW_EN
      c = t - i;
`else
      c = t;
`endif
      if (c >= 0 && c < 4) r[i*8 +: 8] = 8'(base + 4*i + c + 1);
    end
    return r;
  endfunction

  task automatic load_tile(input int base, input bit commit_last);
    for (int r = 0; r < 4; r++) begin
      wr_en     = 1'b1;
      wr_row    = 2'(r);
      wr_data   = row_of(base, r);
      wr_commit = commit_last && (r == 3);
      tick();
    end
    wr_en     = 1'b0;
    wr_commit = 1'b0;
  endtask

  task automatic commit_tile();
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
  endtask

  task automatic stream(input string tag, input int base, input bit poke_mid, input bit chain,
                        output logic [31:0] first, output logic [31:0] last,
                        output logic rdy_at_done);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check({tag, "_pre_a"}, a_out, 32'h0);
    check({tag, "_pre_busy"}, 32'(rd_busy), 32'h0);
    first       = '0;
    last        = '0;
    rdy_at_done = 1'b0;
    for (int k = 0; k < LEN; k++) begin
      if (poke_mid && k == 2) rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      check($sformatf("%s_a%0d", tag, k), a_out, exp_aout(base, k));
      check($sformatf("%s_busy%0d", tag, k), 32'(rd_busy), 32'h1);
      check($sformatf("%s_done%0d", tag, k), 32'(rd_done), 32'(k == LEN - 1));
      if (k == 0) first = a_out;
      if (k == LEN - 1) begin
        last        = a_out;
        rdy_at_done = wr_ready;
      end
    end
    if (chain) rd_start = 1'b1;
    tick();
    check({tag, "_post_a"}, a_out, 32'h0);
    check({tag, "_post_busy"}, 32'(rd_busy), 32'h0);
    check({tag, "_post_done"}, 32'(rd_done), 32'h0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0; wr_commit = 1'b0; rd_start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_a", a_out, 32'h0);
    check("rst_busy", 32'(rd_busy), 32'h0);
    check("rst_done", 32'(rd_done), 32'h0);
    check("rst_rdy", 32'(wr_ready), 32'h1);
    check("rst_cnt", 32'(full_cnt), 32'h0);

    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    check("empty_start_busy", 32'(rd_busy), 32'h0);
    check("empty_start_a", a_out, 32'h0);

    load_tile(0, 1'b0);
    commit_tile();
    check("basic_cnt1", 32'(full_cnt), 32'h1);
    check("basic_rdy", 32'(wr_ready), 32'h1);
    stream("basic", 0, 1'b1, 1'b0, first_v, last_v, dummy_r);
    check("basic_hand_first", first_v, HAND_FIRST);
    check("basic_hand_last", last_v, HAND_LAST);
    check("basic_cnt0", 32'(full_cnt), 32'h0);

    load_tile(32'h20, 1'b0);
    commit_tile();
    check("pp_cnt1", 32'(full_cnt), 32'h1);
    fork
      stream("pp_x", 32'h20, 1'b0, 1'b1, dummy_f, dummy_l, dummy_r);
      begin
        for (int r = 0; r < 4; r++) begin
          check($sformatf("pp_rdy%0d", r), 32'(wr_ready), 32'h1);
          wr_en   = 1'b1;
          wr_row  = 2'(r);
          wr_data = row_of(32'h40, r);
          tick();
        end
        wr_en = 1'b0;
        check("pp_rdy_commit", 32'(wr_ready), 32'h1);
        commit_tile();
        check("pp_cnt2", 32'(full_cnt), 32'h2);
      end
    join
    check("pp_cnt_after_x", 32'(full_cnt), 32'h1);
    stream("pp_y", 32'h40, 1'b0, 1'b0, dummy_f, dummy_l, dummy_r);
    check("pp_cnt_after_y", 32'(full_cnt), 32'h0);

    load_tile(32'h60, 1'b1);
    check("bp_cnt1", 32'(full_cnt), 32'h1);
    load_tile(32'h80, 1'b0);
    commit_tile();
    check("bp_cnt2", 32'(full_cnt), 32'h2);
    check("bp_rdy0", 32'(wr_ready), 32'h0);
    wr_en   = 1'b1;
    wr_row  = 2'd0;
    wr_data = 32'h7F7F_7F7F;
    tick();
    wr_en = 1'b0;
    commit_tile();
    check("bp_ign_commit_cnt", 32'(full_cnt), 32'h2);
    stream("bp_p", 32'h60, 1'b0, 1'b0, dummy_f, dummy_l, rdy_done);
    check("bp_rdy_at_done", 32'(rdy_done), 32'h0);
    check("bp_rdy_after", 32'(wr_ready), 32'h1);
    check("bp_cnt_after", 32'(full_cnt), 32'h1);

    fork
      stream("ce_q", 32'h80, 1'b0, 1'b0, dummy_f, dummy_l, dummy_r);
      begin
        for (int n = 1; n <= LEN + 2; n++) begin
          if (n <= 4) begin
            wr_en   = 1'b1;
            wr_row  = 2'(n - 1);
            wr_data = row_of(32'hA0, n - 1);
          end else begin
            wr_en = 1'b0;
          end
          wr_commit = (n == LEN + 2);
          if (n == LEN + 1) check("ce_cnt_before", 32'(full_cnt), 32'h1);
          tick();
        end
        wr_en     = 1'b0;
        wr_commit = 1'b0;
      end
    join
    check("ce_cnt_net", 32'(full_cnt), 32'h1);
    check("ce_rdy", 32'(wr_ready), 32'h1);

    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (4) tick();
    check("mr_a_t3", a_out, exp_aout(32'hA0, 3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_a", a_out, 32'h0);
    check("mr_busy", 32'(rd_busy), 32'h0);
    check("mr_cnt", 32'(full_cnt), 32'h0);
    check("mr_rdy", 32'(wr_ready), 32'h1);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    check("mr_restart_busy", 32'(rd_busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
